// File: rtl/bn_act_stream_if.sv
// Stream, coefficient-write and result bundle for bn_act_stream.
// The DUT takes the slave modport; the feeding/consuming side takes the master modport.
interface bn_act_stream_if #(
    parameter int unsigned NO_CH   = 4,
    parameter int unsigned BW_IN   = 12,
    parameter int unsigned BW_A    = 12,
    parameter int unsigned BW_B    = 16,
    parameter int unsigned BW_OUT  = 12,
    parameter int unsigned NO_SETS = 4
);
    localparam int unsigned SET_W = (NO_SETS > 1) ? $clog2(NO_SETS) : 1;
    localparam int unsigned CH_W  = (NO_CH > 1) ? $clog2(NO_CH) : 1;

    logic                      in_vld;
    logic                      in_rdy;
    logic [NO_CH*BW_IN-1:0]    data_in;
    logic [SET_W-1:0]          set_sel;
    logic [1:0]                act_mode;
    logic                      coef_we;
    logic [SET_W-1:0]          coef_set;
    logic [CH_W-1:0]           coef_ch;
    logic [BW_A-1:0]           coef_a;
    logic [BW_B-1:0]           coef_b;
    logic                      out_vld;
    logic                      out_rdy;
    logic [NO_CH*BW_OUT-1:0]   data_out;
    logic [NO_CH-1:0]          sat_out;

    modport slave (
        input  in_vld, data_in, set_sel, act_mode,
        input  coef_we, coef_set, coef_ch, coef_a, coef_b,
        input  out_rdy,
        output in_rdy, out_vld, data_out, sat_out
    );

    modport master (
        output in_vld, data_in, set_sel, act_mode,
        output coef_we, coef_set, coef_ch, coef_a, coef_b,
        output out_rdy,
        input  in_rdy, out_vld, data_out, sat_out
    );
endinterface

// File: rtl/bn_act_stream.sv
// Per-channel batch-norm scale/bias with selectable activation and output saturation,
// four-stage valid/ready pipeline with banked coefficient store.
module bn_act_stream #(
    parameter int unsigned NO_CH      = 4,
    parameter int unsigned BW_IN      = 12,
    parameter int unsigned BW_A       = 12,
    parameter int unsigned BW_B       = 16,
    parameter int unsigned BW_OUT     = 12,
    parameter int unsigned R_SHIFT    = 6,
    parameter int unsigned ROUND      = 1,
    parameter int unsigned NO_SETS    = 4,
    parameter int          MAXVAL     = 255,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    bn_act_stream_if.slave    bus
);
    localparam int unsigned SET_W = (NO_SETS > 1) ? $clog2(NO_SETS) : 1;
    localparam int unsigned BW_P  = BW_IN + BW_A;
    localparam int unsigned BW_S  = ((BW_P > BW_B) ? BW_P : BW_B) + 1;

    localparam logic signed [BW_S-1:0] RND_C   = (ROUND != 0) ? (BW_S'(1) <<< (R_SHIFT - 1)) : BW_S'(0);
    localparam logic signed [BW_S-1:0] OUT_HI  = BW_S'((64'sd1 <<< (BW_OUT - 1)) - 64'sd1);
    localparam logic signed [BW_S-1:0] OUT_LO  = ~OUT_HI;
    localparam logic signed [BW_S-1:0] CLIP_HI = BW_S'(MAXVAL);

    logic signed [BW_A-1:0]   r_mem_a [NO_SETS][NO_CH];
    logic signed [BW_B-1:0]   r_mem_b [NO_SETS][NO_CH];

    logic                     w_adv;
    logic                     w_acc;
    logic                     w_wr_ok;
    logic [SET_W-1:0]         w_rd_set;

    logic                     r1_vld, r2_vld, r3_vld, r_out_vld;
    logic [1:0]               r1_mode, r2_mode, r3_mode;
    logic signed [BW_IN-1:0]  r1_x [NO_CH];
    logic signed [BW_A-1:0]   r1_a [NO_CH];
    logic signed [BW_B-1:0]   r1_b [NO_CH];
    logic signed [BW_P-1:0]   r2_p [NO_CH];
    logic signed [BW_B-1:0]   r2_b [NO_CH];
    logic signed [BW_S-1:0]   r3_s [NO_CH];

    logic signed [BW_S-1:0]   w_y   [NO_CH];
    logic signed [BW_S-1:0]   w_act [NO_CH];
    logic [BW_OUT-1:0]        w_res [NO_CH];
    logic [NO_CH-1:0]         w_sat;

    logic [NO_CH*BW_OUT-1:0]  r_data_out;
    logic [NO_CH-1:0]         r_sat_out;

    // One global advance: the whole pipe moves unless the output register is full and blocked.
    assign w_adv        = ~r_out_vld | bus.out_rdy;
    assign w_acc        = bus.in_vld & w_adv;
    assign bus.in_rdy   = w_adv;
    assign bus.out_vld  = r_out_vld;
    assign bus.data_out = r_data_out;
    assign bus.sat_out  = r_sat_out;

    assign w_wr_ok  = (32'(bus.coef_set) < NO_SETS) && (32'(bus.coef_ch) < NO_CH);
    assign w_rd_set = (32'(bus.set_sel) < NO_SETS) ? bus.set_sel : '0;

    // Coefficient store: not reset, written every cycle regardless of stalls.
    always_ff @(posedge clk) begin
        if (bus.coef_we && w_wr_ok) begin
            r_mem_a[bus.coef_set][bus.coef_ch] <= bus.coef_a;
            r_mem_b[bus.coef_set][bus.coef_ch] <= bus.coef_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vld     <= 1'b0;
            r2_vld     <= 1'b0;
            r3_vld     <= 1'b0;
            r_out_vld  <= 1'b0;
            r_data_out <= '0;
            r_sat_out  <= '0;
        end else if (w_adv) begin
            r1_vld    <= w_acc;
            r2_vld    <= r1_vld;
            r3_vld    <= r2_vld;
            r_out_vld <= r3_vld;
            if (r3_vld) begin
                for (int unsigned i = 0; i < NO_CH; i++) begin
                    r_data_out[i*BW_OUT +: BW_OUT] <= w_res[i];
                end
                r_sat_out <= w_sat;
            end
        end
    end

    // Datapath stages S1..S3; the coef read happens at acceptance so later writes never leak in.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_mode <= bus.act_mode;
            r2_mode <= r1_mode;
            r3_mode <= r2_mode;
            for (int unsigned i = 0; i < NO_CH; i++) begin
                r1_x[i] <= bus.data_in[i*BW_IN +: BW_IN];
                r1_a[i] <= r_mem_a[w_rd_set][i];
                r1_b[i] <= r_mem_b[w_rd_set][i];
                r2_p[i] <= BW_P'(r1_a[i]) * BW_P'(r1_x[i]);
                r2_b[i] <= r1_b[i];
                r3_s[i] <= BW_S'(r2_p[i]) + BW_S'(r2_b[i]) + RND_C;
            end
        end
    end

    // S4: floor shift, activation, then output clamp with saturation flag.
    always_comb begin
        w_sat = '0;
        for (int unsigned i = 0; i < NO_CH; i++) begin
            w_y[i]   = r3_s[i] >>> R_SHIFT;
            w_act[i] = w_y[i];
            w_res[i] = '0;
            case (r3_mode)
                2'd1: if (w_y[i][BW_S-1]) w_act[i] = '0;
                2'd2: begin
                    if (w_y[i][BW_S-1])        w_act[i] = '0;
                    else if (w_y[i] > CLIP_HI) w_act[i] = CLIP_HI;
                end
                2'd3: if (w_y[i][BW_S-1]) w_act[i] = w_y[i] >>> LEAK_SHIFT;
                default: ;
            endcase
            if (w_act[i] > OUT_HI) begin
                w_res[i] = BW_OUT'(OUT_HI);
                w_sat[i] = 1'b1;
            end else if (w_act[i] < OUT_LO) begin
                w_res[i] = BW_OUT'(OUT_LO);
                w_sat[i] = 1'b1;
            end else begin
                w_res[i] = BW_OUT'(w_act[i]);
            end
        end
    end
endmodule

// File: tb/tb_bn_act_stream.sv
// Scoreboard bench for bn_act_stream: ROUND=1 and ROUND=0 instances fed identical stimulus,
// expected beats queued at acceptance and popped by an independent output monitor.
module tb_bn_act_stream;
    localparam int unsigned NO_CH = 4, BW_IN = 12, BW_A = 12, BW_B = 16, BW_OUT = 12;
    localparam int unsigned R_SHIFT = 6, NO_SETS = 4, LEAK_SHIFT = 3;
    localparam int          MAXVAL = 255;
    localparam int unsigned SET_W = 2, CH_W = 2;

    typedef struct packed {
        logic [NO_CH*BW_OUT-1:0] d0;
        logic [NO_CH-1:0]        s0;
        logic [NO_CH*BW_OUT-1:0] d1;
        logic [NO_CH-1:0]        s1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bn_act_stream_if #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_A(BW_A), .BW_B(BW_B),
                       .BW_OUT(BW_OUT), .NO_SETS(NO_SETS)) bus0 ();
    bn_act_stream_if #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_A(BW_A), .BW_B(BW_B),
                       .BW_OUT(BW_OUT), .NO_SETS(NO_SETS)) bus1 ();

    assign bus1.in_vld   = bus0.in_vld;
    assign bus1.data_in  = bus0.data_in;
    assign bus1.set_sel  = bus0.set_sel;
    assign bus1.act_mode = bus0.act_mode;
    assign bus1.coef_we  = bus0.coef_we;
    assign bus1.coef_set = bus0.coef_set;
    assign bus1.coef_ch  = bus0.coef_ch;
    assign bus1.coef_a   = bus0.coef_a;
    assign bus1.coef_b   = bus0.coef_b;
    assign bus1.out_rdy  = bus0.out_rdy;

    bn_act_stream #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_A(BW_A), .BW_B(BW_B), .BW_OUT(BW_OUT),
                    .R_SHIFT(R_SHIFT), .ROUND(1), .NO_SETS(NO_SETS), .MAXVAL(MAXVAL),
                    .LEAK_SHIFT(LEAK_SHIFT)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    bn_act_stream #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_A(BW_A), .BW_B(BW_B), .BW_OUT(BW_OUT),
                    .R_SHIFT(R_SHIFT), .ROUND(0), .NO_SETS(NO_SETS), .MAXVAL(MAXVAL),
                    .LEAK_SHIFT(LEAK_SHIFT)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   ma [NO_SETS][NO_CH];
    int   mb [NO_SETS][NO_CH];
    bit   rnd_rdy = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: plain integer arithmetic straight from the scale/bias/activation/clamp rules.
    function automatic void calc(input logic [NO_CH*BW_IN-1:0] xv, input int set, input int mode,
                                 input int rnd, output logic [NO_CH*BW_OUT-1:0] d,
                                 output logic [NO_CH-1:0] s);
        longint hi, lo, x, y;
        hi = (64'sd1 <<< (BW_OUT - 1)) - 1;
        lo = -hi - 1;
        for (int ch = 0; ch < NO_CH; ch++) begin
            x = longint'($signed(xv[ch*BW_IN +: BW_IN]));
            y = fdiv(longint'(ma[set][ch]) * x + longint'(mb[set][ch]) + (rnd != 0 ? 32 : 0),
                     longint'(2 ** R_SHIFT));
            case (mode)
                1: if (y < 0) y = 0;
                2: if (y < 0) y = 0; else if (y > MAXVAL) y = MAXVAL;
                3: if (y < 0) y = fdiv(y, longint'(2 ** LEAK_SHIFT));
                default: ;
            endcase
            s[ch] = (y > hi) || (y < lo);
            if (y > hi) y = hi;
            if (y < lo) y = lo;
            d[ch*BW_OUT +: BW_OUT] = BW_OUT'(y);
        end
    endfunction

    function automatic logic [NO_CH*BW_OUT-1:0] rep(input int v);
        logic [NO_CH*BW_OUT-1:0] r;
        for (int ch = 0; ch < NO_CH; ch++) r[ch*BW_OUT +: BW_OUT] = BW_OUT'(v);
        return r;
    endfunction

    function automatic logic [NO_CH*BW_IN-1:0] xrep(input int v);
        logic [NO_CH*BW_IN-1:0] r;
        for (int ch = 0; ch < NO_CH; ch++) r[ch*BW_IN +: BW_IN] = BW_IN'(v);
        return r;
    endfunction

    task automatic drive_rdy();
        bus0.out_rdy = rnd_rdy ? ($urandom_range(0, 9) < 7) : 1'b1;
    endtask

    task automatic idle(input int n);
        bus0.in_vld = 1'b0;
        repeat (n) begin
            drive_rdy();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input int set, input int ch, input int a, input int b);
        bus0.in_vld   = 1'b0;
        bus0.coef_we  = 1'b1;
        bus0.coef_set = SET_W'(set);
        bus0.coef_ch  = CH_W'(ch);
        bus0.coef_a   = BW_A'(a);
        bus0.coef_b   = BW_B'(b);
        drive_rdy();
        @(posedge clk);
        ma[set][ch] = a;
        mb[set][ch] = b;
        #2;
        bus0.coef_we = 1'b0;
    endtask

    // Holds a beat until accepted; optional coefficient write starts in the same cycle.
    task automatic send(input int set, input int mode, input logic [NO_CH*BW_IN-1:0] xv,
                        input bit use_c0, input logic [NO_CH*BW_OUT-1:0] c0,
                        input logic [NO_CH-1:0] cs0, input bit use_c1,
                        input logic [NO_CH*BW_OUT-1:0] c1, input bit we, input int wset,
                        input int wch, input int wa, input int wb);
        bit   acc;
        bit   wr_now;
        exp_t e;
        acc    = 1'b0;
        wr_now = we;
        bus0.in_vld   = 1'b1;
        bus0.data_in  = xv;
        bus0.set_sel  = SET_W'(set);
        bus0.act_mode = 2'(mode);
        if (we) begin
            bus0.coef_we  = 1'b1;
            bus0.coef_set = SET_W'(wset);
            bus0.coef_ch  = CH_W'(wch);
            bus0.coef_a   = BW_A'(wa);
            bus0.coef_b   = BW_B'(wb);
        end
        for (int k = 0; k < 500 && !acc; k++) begin
            drive_rdy();
            #1;
            acc = bus0.in_rdy;
            @(posedge clk);
            if (acc) begin
                calc(xv, set, mode, 1, e.d0, e.s0);
                calc(xv, set, mode, 0, e.d1, e.s1);
                if (use_c0) begin
                    e.d0 = c0;
                    e.s0 = cs0;
                end
                if (use_c1) e.d1 = c1;
                sb.push_back(e);
            end
            if (wr_now) begin
                ma[wset][wch] = wa;
                mb[wset][wch] = wb;
                wr_now = 1'b0;
            end
            #2;
            bus0.coef_we = 1'b0;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic beat(input int set, input int mode, input int x, input int e0, input bit s0);
        send(set, mode, xrep(x), 1'b1, rep(e0), {NO_CH{s0}}, 1'b0, '0, 1'b0, 0, 0, 0, 0);
    endtask

    // Monitor: pops on every output transfer and checks stability across stall cycles.
    logic                    stall_prev = 1'b0;
    logic [NO_CH*BW_OUT-1:0] prev_d;
    logic [NO_CH-1:0]        prev_s;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_chk++;
                if (!bus0.out_vld || bus0.data_out !== prev_d || bus0.sat_out !== prev_s) begin
                    n_fail++;
                    $display("FAIL stall_hold: got vld=%0b d=%h s=%b expected vld=1 d=%h s=%b",
                             bus0.out_vld, bus0.data_out, bus0.sat_out, prev_d, prev_s);
                end
            end
            if (bus0.out_vld && bus0.out_rdy) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got d=%h expected no beat", bus0.data_out);
                end else begin
                    e = sb.pop_front();
                    n_chk++;
                    if (bus0.data_out !== e.d0 || bus0.sat_out !== e.s0) begin
                        n_fail++;
                        $display("FAIL beat_round1: got d=%h s=%b expected d=%h s=%b",
                                 bus0.data_out, bus0.sat_out, e.d0, e.s0);
                    end
                    n_chk++;
                    if (!bus1.out_vld || bus1.data_out !== e.d1 || bus1.sat_out !== e.s1) begin
                        n_fail++;
                        $display("FAIL beat_round0: got vld=%0b d=%h s=%b expected vld=1 d=%h s=%b",
                                 bus1.out_vld, bus1.data_out, bus1.sat_out, e.d1, e.s1);
                    end
                end
            end
            stall_prev = bus0.out_vld && !bus0.out_rdy;
            prev_d     = bus0.data_out;
            prev_s     = bus0.sat_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int                      lat;
        bit                      seen;
        logic [NO_CH*BW_IN-1:0]  xv;
        logic [NO_CH*BW_OUT-1:0] d;

        bus0.in_vld = 1'b0; bus0.data_in = '0; bus0.set_sel = '0; bus0.act_mode = '0;
        bus0.coef_we = 1'b0; bus0.coef_set = '0; bus0.coef_ch = '0;
        bus0.coef_a = '0; bus0.coef_b = '0; bus0.out_rdy = 1'b1;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_vld", longint'(bus0.out_vld), 0);
        check("rst_in_rdy", longint'(bus0.in_rdy), 1);
        check("rst_data_out", longint'(bus0.data_out), 0);
        check("rst_sat_out", longint'(bus0.sat_out), 0);
        #1;

        for (int ch = 0; ch < NO_CH; ch++) begin
            wr(0, ch, 64, 0);
            wr(1, ch, 128, 0);
            wr(2, ch, 1, 0);
            wr(3, ch, 64, -640);
        end

        beat(0, 1, 100, 100, 1'b0);
        bus0.in_vld = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            lat++;
            #1;
            seen = bus0.out_vld;
            #1;
        end
        check("latency_cycles", lat, 4);

        beat(0, 1, -100, 0, 1'b0);
        beat(0, 0, -100, -100, 1'b0);
        beat(0, 3, -100, -13, 1'b0);
        beat(0, 2, 300, 255, 1'b0);
        send(2, 0, xrep(96), 1'b1, rep(2), '0, 1'b1, rep(1), 1'b0, 0, 0, 0, 0);
        send(2, 0, xrep(95), 1'b1, rep(1), '0, 1'b1, rep(1), 1'b0, 0, 0, 0, 0);
        beat(3, 0, 100, 90, 1'b0);
        beat(0, 1, 10, 10, 1'b0);
        beat(1, 1, 10, 20, 1'b0);
        beat(0, 1, 10, 10, 1'b0);
        beat(1, 1, 10, 20, 1'b0);
        send(1, 1, xrep(10), 1'b1, rep(20), '0, 1'b0, '0, 1'b1, 1, 0, 192, 0);
        d = rep(20);
        d[0 +: BW_OUT] = BW_OUT'(30);
        send(1, 1, xrep(10), 1'b1, d, '0, 1'b0, '0, 1'b0, 0, 0, 0, 0);
        idle(6);

        for (int ch = 0; ch < NO_CH; ch++) wr(2, ch, 2047, 0);
        beat(2, 0, 2047, 2047, 1'b1);
        beat(2, 0, -2048, -2048, 1'b1);
        idle(8);

        // Randomised traffic with random backpressure and interleaved coefficient writes.
        rnd_rdy = 1'b1;
        for (int s = 0; s < NO_SETS; s++)
            for (int ch = 0; ch < NO_CH; ch++)
                wr(s, ch, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 65535)) - 32768);
        for (int n = 0; n < 200; n++) begin
            for (int ch = 0; ch < NO_CH; ch++) xv[ch*BW_IN +: BW_IN] = BW_IN'($urandom);
            send(int'($urandom_range(0, NO_SETS - 1)), int'($urandom_range(0, 3)), xv,
                 1'b0, '0, '0, 1'b0, '0, ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, NO_SETS - 1)), int'($urandom_range(0, NO_CH - 1)),
                 int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 65535)) - 32768);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        rnd_rdy = 1'b0;
        for (int k = 0; k < 60 && sb.size() != 0; k++) idle(1);
        check("drain_random", sb.size(), 0);

        // Reset with three beats in flight; coefficients must survive.
        for (int ch = 0; ch < NO_CH; ch++) wr(0, ch, 64, 0);
        for (int n = 0; n < 3; n++) begin
            for (int ch = 0; ch < NO_CH; ch++) xv[ch*BW_IN +: BW_IN] = BW_IN'($urandom);
            send(0, 0, xv, 1'b0, '0, '0, 1'b0, '0, 1'b0, 0, 0, 0, 0);
        end
        bus0.in_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        sb.delete();
        #1;
        check("reset_flush_out_vld", longint'(bus0.out_vld), 0);
        #1 rst = 1'b0;
        idle(8);
        beat(0, 0, 10, 10, 1'b0);
        for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
        check("drain_after_reset", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bn_act_stream.md
# bn_act_stream

Per-channel batch-norm scale/bias plus selectable activation on a valid/ready stream, the parametrised successor of the fixed-point BN+ReLU stage. Holds NO_SETS banks of per-channel coefficients, selected per beat, so one instance serves several layers. Applies optional round-to-nearest and full output saturation. Sits between a convolution accumulator output and the next layer's input buffer, with backpressure propagated upstream.

## Interface
- NO_CH, 4: channels per beat
- BW_IN, 12: signed input sample width
- BW_A, 12: signed scale width
- BW_B, 16: signed bias width, same binary point as the product
- BW_OUT, 12: signed output width
- R_SHIFT, 6: arithmetic right shift after bias; must be ≥1
- ROUND, 1: 1 adds 2^(R_SHIFT-1) before the shift
- NO_SETS, 4: coefficient banks; SET_W = max(1, clog2(NO_SETS))
- MAXVAL, 255: clip ceiling for mode 2; must be >0 and ≤2^(BW_OUT-1)-1
- LEAK_SHIFT, 3: negative-slope shift for mode 3
- clk  in  1  clock; the only clock
- rst  in  1  reset, synchronous, active-high
- in_vld  in  1  input beat valid
- in_rdy  out  1  block accepts the beat this cycle
- data_in  in  NO_CH×BW_IN  samples, channel i at [i]
- set_sel  in  SET_W  coefficient bank for this beat
- act_mode  in  2  0 identity, 1 ReLU, 2 clipped ReLU, 3 leaky ReLU
- coef_we  in  1  coefficient write strobe
- coef_set  in  SET_W  bank written
- coef_ch  in  clog2(NO_CH)  channel written
- coef_a  in  BW_A  scale value
- coef_b  in  BW_B  bias value
- out_vld  out  1  output beat valid
- out_rdy  in  1  downstream accepts
- data_out  out  NO_CH×BW_OUT  activated results
- sat_out  out  NO_CH  per-channel flag: the result was clamped by saturation (not ReLU zeroing or MAXVAL clip)

## Operation
- A beat is accepted when in_vld & in_rdy. set_sel and act_mode are captured with it and travel down the pipe.
- Coefficient store: NO_SETS×NO_CH entries of {a,b}, registered read. Contents are not reset; software loads them before use.
- A write lands at the clock edge. A beat accepted in the same cycle as a write to its bank/channel sees the old value. Beats accepted later see the new value.
- Write with out-of-range coef_set is ignored.
- Per channel:
  - p = a·x, signed, BW_IN+BW_A bits.
  - s = p + sign-extended b + (ROUND ? 2^(R_SHIFT-1) : 0), computed in BW_S = max(BW_IN+BW_A, BW_B)+1 bits with no overflow.
  - y = s >>> R_SHIFT (floor).
- Activation:
  - Mode 0: y.
  - Mode 1: y<0 → 0.
  - Mode 2: y<0 → 0; y>MAXVAL → MAXVAL.
  - Mode 3: y<0 → y >>> LEAK_SHIFT.
- After activation, the result is clamped to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1], and sat_out[i] is set when this clamp changes the value.

## Timing
- Four stages: S1 coef read + input register, S2 multiply, S3 bias/round add, S4 shift/activate/clamp + output register.
- Latency is 4 cycles from acceptance to out_vld when out_rdy is held high. Throughput is 1 beat/cycle.
- Single global advance enable: adv = ~out_vld | out_rdy. in_rdy = adv. All stage registers and their valid bits load only when adv=1.
- With out_vld=1 & out_rdy=0, data_out, sat_out and out_vld hold stable. No beat is lost or duplicated.
- in_rdy may fall while in_vld is high. The source holds its beat until accepted.
- Coefficient writes are independent of adv and are accepted every cycle, including during a stall.
- Reset values: out_vld=0, in_rdy=1 from the first cycle after reset, data_out=0, sat_out=0, and all stage valids 0.
- Reset mid-stream discards all in-flight beats. The coefficient store is retained.

## Test plan
- Basic, mode 1, a=64, b=0, ROUND=1: x=100 → 100; x=-100 → 0; latency exactly 4 cycles.
- Modes with a=64, b=0 and the same x=-100: mode 0 → -100; mode 3 → -13 (-100>>>3). Mode 2 with x=300 → 255, sat_out=0.
- Rounding, a=1, b=0: x=96 → 2 and x=95 → 1 with ROUND=1; x=96 → 1 with ROUND=0. Bias a=64, b=-640, x=100 → 90.
- Saturation, mode 0, a=2047: x=2047 → 2047, sat=1; x=-2048 → -2048, sat=1.
- Banks and writes: load set0 a=64, set1 a=128. Alternate set_sel on back-to-back beats with x=10 → 10, 20, 10, 20. Rewrite set1 a=192 in the same cycle as a set1 beat → that beat gives 20 and the next set1 beat gives 30.
- Backpressure and reset: random out_rdy over 200 beats → output sequence equals the model in order, with data stable while stalled. Assert rst with 3 beats in flight → out_vld=0 next cycle, none of the 3 emerge, and the coefficients survive.
